mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between a pipeline and the HI/LO multiply-divide unit.
// Revision: 1.0
`default_nettype none

interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers, 33-cycle latency.
// Revision: 1.0
`default_nettype none

module mult_div_unit (
  input  wire logic        clk,
  input  wire logic        reset,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [4:0] C_LAST_STEP = 5'd31;

  state_t      r_state;
  logic        r_is_div;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_neg_lo;
  logic        r_neg_hi;
  logic        r_div_zero;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed_op;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic        w_div_ok;
  logic [63:0] w_div_next;
  logic [63:0] w_step_next;
  logic [63:0] w_res_mul;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Operand conditioning: op[0]=1 selects the unsigned variants.
  assign w_signed_op = ~bus.op[0];
  assign w_sa        = w_signed_op & bus.a[31];
  assign w_sb        = w_signed_op & bus.b[31];
  assign w_a_mag     = w_sa ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag     = w_sb ? (32'd0 - bus.b) : bus.b;

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next  = {w_mul_sum, r_acc[31:1]};

  assign w_div_shift = r_acc[63:31];
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
  assign w_div_ok    = ~w_div_diff[33];
  assign w_div_next  = {(w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0]), r_acc[30:0], w_div_ok};

  assign w_step_next = r_is_div ? w_div_next : w_mul_next;

  // A zero divisor leaves rem=|a|, so the dividend-sign fixup restores a exactly.
  assign w_res_mul   = r_neg_lo ? (64'd0 - r_acc) : r_acc;
  assign w_quo       = r_div_zero ? 32'hFFFF_FFFF : (r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
  assign w_rem       = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_opnd     <= 32'd0;
      r_acc      <= 64'd0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= 5'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mthi) r_hi <= bus.a;
          if (bus.mtlo) r_lo <= bus.a;
          if (bus.start) begin
            r_is_div   <= bus.op[1];
            r_opnd     <= w_b_mag;
            r_acc      <= {32'd0, w_a_mag};
            r_neg_lo   <= w_sa ^ w_sb;
            r_neg_hi   <= bus.op[1] ? w_sa : (w_sa ^ w_sb);
            r_div_zero <= bus.op[1] & (bus.b == 32'd0);
            r_cnt      <= 5'd0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_step_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_STEP) r_state <= S_FINISH;
        end
        S_FINISH: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_res_mul[63:32];
            r_lo <= w_res_mul[31:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire
